ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Converts the raw byte stream from `PS2_Controller` (`received_data` / `received_data_en`) into complete key events: make/break, optional E0 extended prefix, and Pause (E1) sequences. Events are queued in a parametrised FIFO and drained through a valid/ready handshake. The block sits between `PS2_Controller` and keyboard consumers such as the display, LED, and game logic. It replaces ad-hoc "last two bytes" tracking with a proper sequence FSM, sequence timeout, and overflow reporting.

## Interface
- `FIFO_DEPTH`, 8: event queue entries. Power of two, ≥2.
- `TIMEOUT_CYCLES`, 100000: idle cycles allowed inside a multi-byte sequence before abort (2 ms at 50 MHz). Must be ≥2.
- `CLOCK_50` in 1: the only clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `received_data` in 8: byte from `PS2_Controller`.
- `received_data_en` in 1: one-cycle strobe; `received_data` is valid while it is high.
- `event_valid` out 1: FIFO non-empty.
- `event_ready` in 1: consumer accepts head entry.
- `event_code` out 8: final scan code of the head event.
- `event_extended` out 1: head event carried an E0 prefix.
- `event_break` out 1: head event is a key release (F0 seen).
- `fifo_count` out $clog2(FIFO_DEPTH+1): current occupancy.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `seq_error` out 1: one-cycle pulse on timeout abort or error byte.

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen, skipping bytes).
- IDLE transitions:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE, with skip counter = 7.
  - AA, FA, EE, FE → discarded, no event.
  - 00 or FF → `seq_error`, stay in IDLE.
  - Any other byte → push {ext=0, brk=0, code}.
- EXT: F0 → EXT_BRK. 00/FF → IDLE + `seq_error`. Other byte → push {1,0,code}, go to IDLE.
- BRK: 00/FF → IDLE + `seq_error`. Other byte → push {0,1,code}, go to IDLE.
- EXT_BRK: 00/FF → IDLE + `seq_error`. Other byte → push {1,1,code}, go to IDLE.
- PAUSE: each byte decrements the skip counter. When it reaches 0, push {0,0,8'hE1} and go to IDLE. Pause has no break event.
- Timeout:
  - A counter runs while state ≠ IDLE and reloads on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`-1 with no byte: go to IDLE, pulse `seq_error`, push nothing.
  - If a byte arrives in the same cycle the timeout expires, the byte wins and is processed in the current state.
- FIFO entries are 10 bits: {extended, break, code}. Outputs are first-word-fall-through from the head.
- Pop happens when `event_valid && event_ready`. `event_ready` while empty is ignored.
- Push while full: the event is dropped, `overflow` is set, and the contents are unchanged. If a push and a pop occur in the same cycle while full, the push is accepted and the count is unchanged.
- A simultaneous push and pop at any other occupancy leaves `fifo_count` unchanged.

## Timing
- Reset values:
  - `event_valid`=0, `event_code`=00, `event_extended`=0, `event_break`=0.
  - `fifo_count`=0, `overflow`=0, `seq_error`=0.
  - FSM in IDLE; timeout and skip counters at 0.
- Reset applied mid-sequence or with the FIFO non-empty discards everything. Bytes arriving during the reset cycle are ignored.
- Latency: a final byte strobed in cycle N is pushed at the end of N. If the FIFO was empty, `event_valid` and the head fields are visible in N+1.
- A pop at the end of cycle M presents the next entry (or `event_valid`=0) in M+1.
- `seq_error` is high for exactly one cycle, the cycle after the offending byte or timeout.
- Back-to-back `received_data_en` on consecutive cycles must be handled. `PS2_Controller` never does this, but the bench drives it.

## Structure
- Package `ps2_pkg`:
  - Byte constants: `PS2_EXT`=E0, `PS2_BRK`=F0, `PS2_PAUSE`=E1, `PS2_BAT_OK`=AA, `PS2_ACK`=FA, `PS2_ECHO`=EE, `PS2_RESEND`=FE, `PS2_ERR0`=00, `PS2_ERR1`=FF.
  - `PAUSE_SKIP`=7.
  - FSM state enum.
  - Event struct {extended, brk, code}.
- One sub-module, `ps2_event_fifo`: parametrised FWFT synchronous FIFO with push/pop, count, and full/empty. The FSM and timeout logic live in the top.

## Test plan
- Make/break: strobe 1C, then F0, 1C → events {0,0,1C} then {0,1,1C}; each `event_valid` rises 1 cycle after its final byte.
- Extended release: E0, F0, 75 → single event {1,1,75}; no events for the prefix bytes.
- Pause: E1 14 77 E1 F0 14 F0 77 → exactly one event {0,0,E1}, emitted after the 8th byte.
- Timeout: F0 then silence for `TIMEOUT_CYCLES` → `seq_error` pulse, no event; a following 1C yields {0,0,1C}.
- Overflow: `event_ready`=0, 9 make codes with `FIFO_DEPTH`=8 → `fifo_count`=8, `overflow`=1, and draining returns the first 8 codes in order. Separately, a push and pop in the same cycle while full keeps the count at 8.
- Reset mid-sequence: E0, then `reset` for 1 cycle, then 75 → event {0,0,75}; all outputs at their reset values in the cycle after reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, FSM state and event record for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int unsigned PAUSE_SKIP = 7;
  localparam int unsigned SKIP_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } ps2_state_t;

  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

  // Keyboard replies to host commands; never part of a key event.
  function automatic logic is_reply_byte(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Key-event stream: first-word-fall-through head of the event queue with valid/ready.
interface ps2_scancode_decoder_if;
  logic       event_valid;
  logic       event_ready;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_break;

  modport master (
    output event_valid,
    output event_code,
    output event_extended,
    output event_break,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_code,
    input  event_extended,
    input  event_break,
    output event_ready
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is taken only if a pop frees a slot.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  ps2_event_t                   data,
  input  logic                         pop,
  output ps2_event_t                   head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ps2_event_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as all-zero while empty so stale entries never leak out.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Assembles PS/2 scan-code bytes (E0/F0 prefixes, E1 pause) into key events and queues them.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                              CLOCK_50,
  input  logic                              reset,
  input  logic [7:0]                        received_data,
  input  logic                              received_data_en,
  ps2_scancode_decoder_if.master            evt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              seq_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t        state;
  logic [TW-1:0]     tmo_cnt;
  logic [SKIP_W-1:0] skip_cnt;
  logic              push;
  ps2_event_t        push_evt;
  ps2_event_t        head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              byte_err;

  assign byte_err = is_err_byte(received_data);
  assign pop      = evt.event_valid && evt.event_ready;

  // The final byte of a sequence must reach the queue on its own edge.
  always_comb begin
    push     = 1'b0;
    push_evt = '{extended: 1'b0, brk: 1'b0, code: received_data};
    if (received_data_en) begin
      case (state)
        IDLE: push = !byte_err && !is_reply_byte(received_data) &&
                     (received_data != PS2_EXT) && (received_data != PS2_BRK) &&
                     (received_data != PS2_PAUSE);
        EXT: begin
          push              = !byte_err && (received_data != PS2_BRK);
          push_evt.extended = 1'b1;
        end
        BRK: begin
          push         = !byte_err;
          push_evt.brk = 1'b1;
        end
        EXT_BRK: begin
          push              = !byte_err;
          push_evt.extended = 1'b1;
          push_evt.brk      = 1'b1;
        end
        PAUSE: begin
          push          = (skip_cnt == SKIP_W'(1));
          push_evt.code = PS2_PAUSE;
        end
        default: push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      skip_cnt  <= '0;
      seq_error <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      seq_error <= 1'b0;
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (received_data_en) begin
        tmo_cnt <= TMO_LOAD;
        case (state)
          IDLE: begin
            if (byte_err) begin
              seq_error <= 1'b1;
            end else if (received_data == PS2_EXT) begin
              state <= EXT;
            end else if (received_data == PS2_BRK) begin
              state <= BRK;
            end else if (received_data == PS2_PAUSE) begin
              state    <= PAUSE;
              skip_cnt <= SKIP_W'(PAUSE_SKIP);
            end
          end
          EXT: begin
            if (byte_err) begin
              state     <= IDLE;
              seq_error <= 1'b1;
            end else if (received_data == PS2_BRK) begin
              state <= EXT_BRK;
            end else begin
              state <= IDLE;
            end
          end
          BRK, EXT_BRK: begin
            state     <= IDLE;
            seq_error <= byte_err;
          end
          PAUSE: begin
            skip_cnt <= skip_cnt - SKIP_W'(1);
            if (skip_cnt == SKIP_W'(1)) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Silence inside a sequence: abort once the reload value has counted down.
        if (tmo_cnt == '0) begin
          state     <= IDLE;
          skip_cnt  <= '0;
          seq_error <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt - TW'(1);
        end
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (reset),
    .push  (push),
    .data  (push_evt),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign evt.event_valid    = !fifo_empty;
  assign evt.event_code     = head.code;
  assign evt.event_extended = head.extended;
  assign evt.event_break    = head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: byte table plus pause, timeout, overflow and reset sequences.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       seq_error;

  ps2_scancode_decoder_if evt ();

  ps2_scancode_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .evt              (evt),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .seq_error        (seq_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [9:0] head;
    logic       valid;
    logic [3:0] count;
    logic       err;
  } vec_t;

  vec_t vecs [17];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [9:0] head_now();
    return {evt.event_extended, evt.event_break, evt.event_code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe one byte for a single cycle; returns at the negedge after the consuming edge.
  task automatic send(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [9:0] exp);
    check(name, {31'(0), evt.event_valid} << 10 | 32'(head_now()), {22'(0), 1'b1, exp});
    evt.event_ready = 1'b1;
    @(negedge clk);
    evt.event_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_outs"}, {evt.event_valid, head_now(), fifo_count, overflow, seq_error}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'hFE, 10'h000, 1'b0, 4'd0, 1'b0};
    vecs[1]  = '{8'h1C, 10'h01C, 1'b1, 4'd1, 1'b0};
    vecs[2]  = '{8'hF0, 10'h01C, 1'b1, 4'd1, 1'b0};
    vecs[3]  = '{8'h1C, 10'h01C, 1'b1, 4'd2, 1'b0};
    vecs[4]  = '{8'hE0, 10'h01C, 1'b1, 4'd2, 1'b0};
    vecs[5]  = '{8'hF0, 10'h01C, 1'b1, 4'd2, 1'b0};
    vecs[6]  = '{8'h75, 10'h01C, 1'b1, 4'd3, 1'b0};
    vecs[7]  = '{8'hAA, 10'h01C, 1'b1, 4'd3, 1'b0};
    vecs[8]  = '{8'h00, 10'h01C, 1'b1, 4'd3, 1'b1};
    vecs[9]  = '{8'hE0, 10'h01C, 1'b1, 4'd3, 1'b0};
    vecs[10] = '{8'h74, 10'h01C, 1'b1, 4'd4, 1'b0};
    vecs[11] = '{8'hE0, 10'h01C, 1'b1, 4'd4, 1'b0};
    vecs[12] = '{8'hFF, 10'h01C, 1'b1, 4'd4, 1'b1};
    vecs[13] = '{8'h29, 10'h01C, 1'b1, 4'd5, 1'b0};
    vecs[14] = '{8'hF0, 10'h01C, 1'b1, 4'd5, 1'b0};
    vecs[15] = '{8'hFF, 10'h01C, 1'b1, 4'd5, 1'b1};
    vecs[16] = '{8'hFA, 10'h01C, 1'b1, 4'd5, 1'b0};

    reset            = 1'b1;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    evt.event_ready  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Back-to-back bytes, consumer stalled.
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].b);
      check($sformatf("vec%0d", i),
            {17'(0), vecs[i].valid, vecs[i].head, vecs[i].count, vecs[i].err},
            {17'(0), evt.event_valid, head_now(), fifo_count, seq_error});
    end
    pop_expect("drain_make_1c", 10'h01C);
    pop_expect("drain_break_1c", 10'h11C);
    pop_expect("drain_ext_break_75", 10'h375);
    pop_expect("drain_ext_make_74", 10'h274);
    pop_expect("drain_make_29", 10'h029);
    evt.event_ready = 1'b1;
    @(negedge clk);
    evt.event_ready = 1'b0;
    check("ready_while_empty", {evt.event_valid, fifo_count}, 5'h0);

    // Pause: one event only after the eighth byte.
    begin
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 7; i++) send(pause_seq[i]);
      check("pause_no_early_event", fifo_count, 4'd0);
      send(pause_seq[7]);
      check("pause_event", {fifo_count, head_now()}, {4'd1, 10'h0E1});
      pop_expect("pause_drain", 10'h0E1);
    end

    // Timeout after a lone F0.
    begin
      int waited = 0;
      send(8'hF0);
      for (int i = 1; i <= TMO + 5 && waited == 0; i++) begin
        @(negedge clk);
        if (seq_error) waited = i;
      end
      check("timeout_latency", waited, TMO);
      @(negedge clk);
      check("timeout_pulse_single", {seq_error, fifo_count}, 5'h0);
      send(8'h1C);
      check("after_timeout_make", {fifo_count, head_now()}, {4'd1, 10'h01C});
      pop_expect("after_timeout_drain", 10'h01C);
    end

    // Byte arriving on the expiry cycle is processed, not aborted.
    send(8'hF0);
    repeat (TMO - 1) @(negedge clk);
    send(8'h1C);
    check("expiry_byte_wins", {seq_error, fifo_count, head_now()}, {1'b0, 4'd1, 10'h11C});
    pop_expect("expiry_drain", 10'h11C);

    // Overflow: nine makes into an eight-deep queue.
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    check("full_no_overflow_yet", {fifo_count, overflow}, {4'd8, 1'b0});
    send(8'h18);
    check("overflow_set", {fifo_count, overflow}, {4'd8, 1'b1});
    for (int i = 0; i < 8; i++) pop_expect($sformatf("ovf_drain%0d", i), 10'h010 + 10'(i));
    check("ovf_drained", {evt.event_valid, overflow}, 2'b01);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    evt.event_ready = 1'b1;
    send(8'h28);
    evt.event_ready = 1'b0;
    check("full_push_pop", {fifo_count, head_now()}, {4'd8, 10'h021});
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("pp_drain%0d", i), 10'h020 + 10'(i));

    // Reset mid-sequence with a queued event and a byte during reset.
    send(8'h1C);
    send(8'hE0);
    reset            = 1'b1;
    received_data    = 8'hF0;
    received_data_en = 1'b1;
    @(negedge clk);
    reset            = 1'b0;
    received_data_en = 1'b0;
    check_idle_outputs("mid_reset");
    send(8'h75);
    check("post_reset_make", {fifo_count, head_now()}, {4'd1, 10'h075});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
